cswap_sort_ctrl: RTL and testbench

CSWAP_SORT_CTRL -- requirements
Module: cswap_sort_ctrl

---
 rtl/cswap_pkg.sv | 19 +
 rtl/cswap_word.sv | 25 ++
 rtl/cswap_sort_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cswap_sort_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cswap_pkg.sv
// rtl/cswap_pkg.sv - shared states, default sizes and pair-count helper for the compare-swap sorter
package cswap_pkg;

    localparam int CSWAP_DEFAULT_N = 4;
    localparam int CSWAP_DEFAULT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } cswap_state_e;

    // Number of adjacent compares in a full bubble sort of n words, which is
    // also the largest possible swap count for one job.
    function automatic int cswap_pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/cswap_word.sv
// rtl/cswap_word.sv - W-bit combinational controlled swap, ordering a pair ascending
module cswap_word #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         swap_o,
    output logic [W-1:0] lo_o,
    output logic [W-1:0] hi_o
);

    // Strict compare keeps equal words in place so the sort stays stable.
    assign swap_o = (a_i > b_i);

    // Route (b,a) when swapping, (a,b) otherwise.
    always_comb begin
        lo_o = a_i;
        hi_o = b_i;
        if (swap_o) begin
            lo_o = b_i;
            hi_o = a_i;
        end
    end

endmodule

// File: rtl/cswap_sort_ctrl.sv
// rtl/cswap_sort_ctrl.sv - serial bubble-sort controller, one compare-swap per cycle; optional CSWAP_SORT_EARLY_EXIT_EN
module cswap_sort_ctrl
    import cswap_pkg::*;
#(
    parameter int N = CSWAP_DEFAULT_N,
    parameter int W = CSWAP_DEFAULT_W,
    localparam int SCW = $clog2(cswap_pairs(N) + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic           busy,
    output logic [SCW-1:0] swap_cnt
);

    // Index/pass counters only ever reach N-2, so clog2(N) bits suffice.
    localparam int IW = $clog2(N);
    localparam logic [SCW-1:0] SWAP_MAX = SCW'(cswap_pairs(N));

    cswap_state_e         state_q, state_d;
    logic [N-1:0][W-1:0]  arr_q, arr_d;
    logic [IW-1:0]        i_q, i_d;
    logic [IW-1:0]        p_q, p_d;
    logic [SCW-1:0]       cnt_q, cnt_d;

    logic [IW-1:0]        i_nxt;
    logic [IW-1:0]        last_i;
    logic                 pass_end;
    logic                 last_pass;

    logic [W-1:0]         cmp_a, cmp_b, cmp_lo, cmp_hi;
    logic                 cmp_swap;

`ifdef CSWAP_SORT_EARLY_EXIT_EN
    logic                 pass_swap_q, pass_swap_d;
`endif

    assign i_nxt     = i_q + IW'(1);
    assign last_i    = IW'(N - 2) - p_q;
    assign pass_end  = (i_q == last_i);
    assign last_pass = (p_q == IW'(N - 2));

    assign cmp_a = arr_q[i_q];
    assign cmp_b = arr_q[i_nxt];

    // The single shared comparator walks across the array one pair per cycle.
    cswap_word #(
        .W (W)
    ) u_cswap_word (
        .a_i    (cmp_a),
        .b_i    (cmp_b),
        .swap_o (cmp_swap),
        .lo_o   (cmp_lo),
        .hi_o   (cmp_hi)
    );

    // Handshake and status outputs decode straight from the state register,
    // so an asynchronous reset shows up on them without waiting for a clock.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SORT);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = arr_q;
    assign swap_cnt  = cnt_q;

    // Next-state logic: load in IDLE, one compare-swap per SORT cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        arr_d   = arr_q;
        i_d     = i_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
`ifdef CSWAP_SORT_EARLY_EXIT_EN
        pass_swap_d = pass_swap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    arr_d   = in_data;
                    cnt_d   = '0;
                    i_d     = '0;
                    p_d     = '0;
`ifdef CSWAP_SORT_EARLY_EXIT_EN
                    pass_swap_d = 1'b0;
`endif
                    state_d = ST_SORT;
                end
            end
            ST_SORT: begin
                if (cmp_swap) begin
                    arr_d[i_q]   = cmp_lo;
                    arr_d[i_nxt] = cmp_hi;
                    if (cnt_q != SWAP_MAX) begin
                        cnt_d = cnt_q + SCW'(1);
                    end
                end
`ifdef CSWAP_SORT_EARLY_EXIT_EN
                pass_swap_d = pass_swap_q | cmp_swap;
`endif
                if (pass_end) begin
                    i_d = '0;
                    p_d = p_q + IW'(1);
`ifdef CSWAP_SORT_EARLY_EXIT_EN
                    pass_swap_d = 1'b0;
                    // A pass with no swaps proves the array is already ordered.
                    if (last_pass || !(pass_swap_q | cmp_swap)) begin
                        p_d     = '0;
                        state_d = ST_DONE;
                    end
`else
                    if (last_pass) begin
                        p_d     = '0;
                        state_d = ST_DONE;
                    end
`endif
                end else begin
                    i_d = i_nxt;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            arr_q   <= '0;
            i_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            arr_q   <= arr_d;
            i_q     <= i_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CSWAP_SORT_EARLY_EXIT_EN
    // Per-pass flag recording whether any swap happened in the current pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_swap_q <= 1'b0;
        end else begin
            pass_swap_q <= pass_swap_d;
        end
    end
`endif

endmodule

// File: tb/tb_cswap_sort_ctrl.sv
// tb/tb_cswap_sort_ctrl.sv - randomized self-checking bench for cswap_sort_ctrl against a sorting reference model
module tb_cswap_sort_ctrl;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int SCW = $clog2(N * (N - 1) / 2 + 1);

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic           busy;
    logic [SCW-1:0] swap_cnt;

    int n_checks;
    int n_pass;

    cswap_sort_ctrl #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .swap_cnt  (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [N*W-1:0] v;
        v = '0;
        v[0*W +: W] = W'(a0);
        v[1*W +: W] = W'(a1);
        v[2*W +: W] = W'(a2);
        v[3*W +: W] = W'(a3);
        return v;
    endfunction

    // Reference: textbook bubble sort on an int array, counting compares and swaps.
    task automatic ref_sort(input logic [N*W-1:0] din, output logic [N*W-1:0] dout,
                            output int swaps, output int cycles);
        int a[N];
        int t;
        int pass_swaps;
        for (int k = 0; k < N; k++) a[k] = int'(din[k*W +: W]);
        swaps  = 0;
        cycles = 0;
        for (int p = 0; p < N - 1; p++) begin
            pass_swaps = 0;
            for (int k = 0; k < N - 1 - p; k++) begin
                cycles++;
                if (a[k] > a[k+1]) begin
                    t = a[k]; a[k] = a[k+1]; a[k+1] = t;
                    swaps++;
                    pass_swaps++;
                end
            end
`ifdef CSWAP_SORT_EARLY_EXIT_EN
            if (pass_swaps == 0) break;
`endif
        end
        dout = '0;
        for (int k = 0; k < N; k++) dout[k*W +: W] = W'(a[k]);
    endtask

    // Load one job, measure SORT cycles, then hold DONE for `hold` cycles before accepting.
    task automatic run_job(input string name, input logic [N*W-1:0] din, input int hold);
        logic [N*W-1:0] exp_data;
        int exp_swaps;
        int exp_cycles;
        int sort_cyc;
        bit got;
        ref_sort(din, exp_data, exp_swaps, exp_cycles);

        @(negedge clk);
        check({name, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        out_ready = (hold == 0);
        in_data   = din;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = N*W'($urandom);

        sort_cyc = 0;
        got      = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            if (busy) sort_cyc++;
        end
        check({name, ".done_reached"}, 64'(got), 64'd1);
        if (!got) return;
        check({name, ".out_data"},    64'(out_data), 64'(exp_data));
        check({name, ".swap_cnt"},    64'(swap_cnt), 64'(exp_swaps));
        check({name, ".sort_cycles"}, 64'(sort_cyc), 64'(exp_cycles));

        for (int h = 0; h < hold; h++) begin
            check({name, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({name, ".hold_data"},  64'(out_data),  64'(exp_data));
            check({name, ".hold_ready"}, 64'(in_ready),  64'd0);
            in_valid = (h % 2 == 0);
            in_data  = N*W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            check({name, ".hold_end_data"}, 64'(out_data), 64'(exp_data));
            check({name, ".hold_end_cnt"},  64'(swap_cnt), 64'(exp_swaps));
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({name, ".left_done"},  64'(out_valid), 64'd0);
        check({name, ".back_idle"},  64'(in_ready),  64'd1);
        check({name, ".not_busy"},   64'(busy),      64'd0);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".in_ready"},  64'(in_ready),  64'd1);
        check({name, ".out_valid"}, 64'(out_valid), 64'd0);
        check({name, ".busy"},      64'(busy),      64'd0);
        check({name, ".swap_cnt"},  64'(swap_cnt),  64'd0);
        check({name, ".out_data"},  64'(out_data),  64'd0);
    endtask

    logic [N*W-1:0] rnd;
    int sc_cycles;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        run_job("mixed",    pack4(3, 1, 4, 2), 0);
        run_job("reverse",  pack4(4, 3, 2, 1), 0);
        run_job("sorted",   pack4(1, 2, 3, 4), 0);
        run_job("hold5",    pack4(9, 200, 0, 17), 5);
        run_job("equal",    pack4(5, 5, 5, 5), 1);
        run_job("extremes", pack4(255, 0, 255, 0), 2);

        // Reset in the middle of SORT: the job is dropped and a new load is taken immediately.
        @(negedge clk);
        in_data  = pack4(4, 3, 2, 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        sc_cycles = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy) sc_cycles++;
        end
        check("midsort.busy_before", 64'(sc_cycles), 64'd3);
        rst_n = 1'b0;
        #1;
        check_reset_values("midsort_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_job("after_rst", pack4(2, 2, 1, 1), 0);

        for (int r = 0; r < 20; r++) begin
            rnd = N*W'($urandom);
            if (r % 5 == 0) rnd[W-1:0] = rnd[2*W-1:W];
            run_job("random", rnd, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
